// File: rtl/priority_encoder.sv
// Registered N-to-log2(N) priority encoder with enable and valid flag.
// Optional one-hot grant output is built when PRIENC_ONEHOT_EN is defined.
module priority_encoder #(
   parameter int WIDTH    = 8,
   parameter bit MSB_PRIO = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [WIDTH-1:0]         i,
`ifdef PRIENC_ONEHOT_EN
   output logic [WIDTH-1:0]         grant,
`endif
   output logic [$clog2(WIDTH)-1:0] y,
   output logic                     valid
);

   localparam int YW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [YW-1:0] y_nxt;
   logic          valid_nxt;

   // Walk bits from lowest to highest priority so the last hit is the winner.
   always_comb begin
      y_nxt     = '0;
      valid_nxt = 1'b0;
      if (en) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (MSB_PRIO) begin
               if (i[k]) begin
                  y_nxt     = YW'(k);
                  valid_nxt = 1'b1;
               end
            end else begin
               if (i[WIDTH-1-k]) begin
                  y_nxt     = YW'(WIDTH-1-k);
                  valid_nxt = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= '0;
         valid <= 1'b0;
      end else begin
         y     <= y_nxt;
         valid <= valid_nxt;
      end
   end

`ifdef PRIENC_ONEHOT_EN
   logic [WIDTH-1:0] grant_nxt;

   always_comb begin
      grant_nxt = '0;
      if (valid_nxt) grant_nxt = ONE << y_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) grant <= '0;
      else        grant <= grant_nxt;
   end
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: MSB- and LSB-priority instances
// share stimulus; expected results go through a scoreboard queue.
module tb_priority_encoder;

   localparam int WIDTH = 8;
   localparam int YW    = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             en    = 1'b1;
   logic [WIDTH-1:0] i     = 8'hFF;
   logic [YW-1:0]    y_m, y_l;
   logic             valid_m, valid_l;
`ifdef PRIENC_ONEHOT_EN
   logic [WIDTH-1:0] grant_m, grant_l;
`endif

   always #5 clk = ~clk;

   priority_encoder #(.WIDTH(WIDTH), .MSB_PRIO(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
`ifdef PRIENC_ONEHOT_EN
      .grant(grant_m),
`endif
      .y(y_m), .valid(valid_m)
   );

   priority_encoder #(.WIDTH(WIDTH), .MSB_PRIO(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
`ifdef PRIENC_ONEHOT_EN
      .grant(grant_l),
`endif
      .y(y_l), .valid(valid_l)
   );

   typedef struct {
      logic [YW-1:0] y_m;
      logic [YW-1:0] y_l;
      logic          valid;
   } exp_t;

   typedef struct {
      logic             en;
      logic [WIDTH-1:0] i;
      logic [YW-1:0]    y_m;
      logic [YW-1:0]    y_l;
      logic             valid;
   } vec_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;

   function automatic exp_t model(input logic e, input logic [WIDTH-1:0] v);
      exp_t r;
      r.y_m   = '0;
      r.y_l   = '0;
      r.valid = e && (v != '0);
      if (r.valid) begin
         for (int k = WIDTH-1; k >= 0; k--)
            if (v[k]) begin r.y_m = 3'(k); break; end
         for (int k = 0; k < WIDTH; k++)
            if (v[k]) begin r.y_l = 3'(k); break; end
      end
      return r;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_zero(input string nm);
      cmp({nm, " y_m"}, 32'(y_m), 32'd0);
      cmp({nm, " valid_m"}, 32'(valid_m), 32'd0);
      cmp({nm, " y_l"}, 32'(y_l), 32'd0);
      cmp({nm, " valid_l"}, 32'(valid_l), 32'd0);
`ifdef PRIENC_ONEHOT_EN
      cmp({nm, " grant_m"}, 32'(grant_m), 32'd0);
      cmp({nm, " grant_l"}, 32'(grant_l), 32'd0);
`endif
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         cmp({nm, " scoreboard empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      cmp({nm, " y_m"}, 32'(y_m), 32'(e.y_m));
      cmp({nm, " valid_m"}, 32'(valid_m), 32'(e.valid));
      cmp({nm, " y_l"}, 32'(y_l), 32'(e.y_l));
      cmp({nm, " valid_l"}, 32'(valid_l), 32'(e.valid));
`ifdef PRIENC_ONEHOT_EN
      cmp({nm, " grant_m"}, 32'(grant_m), e.valid ? (32'd1 << e.y_m) : 32'd0);
      cmp({nm, " grant_l"}, 32'(grant_l), e.valid ? (32'd1 << e.y_l) : 32'd0);
`endif
   endtask

   task automatic drive(input logic e, input logic [WIDTH-1:0] v, input exp_t x, input string nm);
      @(negedge clk);
      en = e;
      i  = v;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out(nm);
   endtask

   vec_t vecs[$];

   initial begin
      vec_t t;
      exp_t x;
      logic e;
      logic [WIDTH-1:0] v;

      vecs.push_back('{1'b0, 8'hFF, 3'd0, 3'd0, 1'b0});
      vecs.push_back('{1'b1, 8'h7F, 3'd6, 3'd0, 1'b1});
      vecs.push_back('{1'b1, 8'hFF, 3'd7, 3'd0, 1'b1});
      vecs.push_back('{1'b1, 8'h00, 3'd0, 3'd0, 1'b0});
      for (int k = 0; k < WIDTH; k++) begin
         t.en = 1'b1; t.i = 8'(1 << k); t.y_m = 3'(k); t.y_l = 3'(k); t.valid = 1'b1;
         vecs.push_back(t);
      end
      vecs.push_back('{1'b1, 8'h28, 3'd5, 3'd3, 1'b1});
      vecs.push_back('{1'b1, 8'h81, 3'd7, 3'd0, 1'b1});
      vecs.push_back('{1'b1, 8'hFE, 3'd7, 3'd1, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 3'd0, 3'd0, 1'b0});

      // Held in reset with requests active: outputs must stay clear.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_zero("reset hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < vecs.size(); n++) begin
         x.y_m = vecs[n].y_m; x.y_l = vecs[n].y_l; x.valid = vecs[n].valid;
         drive(vecs[n].en, vecs[n].i, x, $sformatf("vec%0d", n));
      end

      // Back-to-back: full throughput, one-cycle lag.
      drive(1'b1, 8'hFF, '{3'd7, 3'd0, 1'b1}, "b2b ff");
      drive(1'b1, 8'h00, '{3'd0, 3'd0, 1'b0}, "b2b 00");

      // Async reset mid-cycle clears a live result without a clock edge.
      drive(1'b1, 8'h18, '{3'd4, 3'd3, 1'b1}, "pre-async");
      rst_n = 1'b0;
      #1;
      check_zero("async clear");
      #2;
      check_zero("async hold");
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 1000; n++) begin
         e = ($urandom_range(0, 3) != 0);
         v = 8'($urandom);
         if ($urandom_range(0, 7) == 0) v = '0;
         drive(e, v, model(e, v), $sformatf("rand%0d", n));
      end

      cmp("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
